// File: rtl/vin_cfa_sequencer_if.sv
// Bus bundle between the video source and the CFA sequencer.
// The sequencer takes the slave modport; the source or bench takes the master modport.
interface vin_cfa_sequencer_if #(
  parameter int unsigned PIX_W = 12
) ();
  logic             i_vsync;
  logic             i_hsync;
  logic             i_valid;
  logic [1:0]       i_cfg_mode;
  logic             i_cfg_wr;
  logic [1:0]       o_phase_x;
  logic [1:0]       o_phase_y;
  logic [1:0]       o_mode;
  logic             o_frame_start;
  logic [PIX_W-1:0] o_pix_cnt;
  logic [PIX_W-1:0] o_line_cnt;
  logic             o_line_err;

  modport master (
    output i_vsync, i_hsync, i_valid, i_cfg_mode, i_cfg_wr,
    input  o_phase_x, o_phase_y, o_mode, o_frame_start, o_pix_cnt, o_line_cnt, o_line_err
  );

  modport slave (
    input  i_vsync, i_hsync, i_valid, i_cfg_mode, i_cfg_wr,
    output o_phase_x, o_phase_y, o_mode, o_frame_start, o_pix_cnt, o_line_cnt, o_line_err
  );
endinterface

// File: rtl/vin_cfa_sequencer.sv
// Frame/line/beat tracker producing CFA phase and shadowed colour mode for the input mixer.
// Optional line-length checker enabled by defining VIN_SEQ_LINECHK_EN.
module vin_cfa_sequencer #(
  parameter int unsigned PIX_W    = 12,
  parameter logic [1:0]  DEF_MODE = 2'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  vin_cfa_sequencer_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_VBLANK = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;
  localparam logic [1:0] ST_HBLANK = 2'd3;

  localparam logic [1:0] MODE_MONO = 2'd0;
  localparam logic [1:0] MODE_TRI  = 2'd1;
  localparam logic [1:0] MODE_RGBW = 2'd2;

  localparam logic [PIX_W-1:0] CNT_ONE = {{(PIX_W-1){1'b0}}, 1'b1};
  localparam logic [PIX_W-1:0] CNT_MAX = {PIX_W{1'b1}};

  logic [1:0]       r_state;
  logic [1:0]       r_mode;
  logic [1:0]       r_pending;
  logic [1:0]       r_phase_x;
  logic [1:0]       r_phase_y;
  logic             r_frame_start;
  logic             r_hs_last;
  logic [PIX_W-1:0] r_pix_cnt;
  logic [PIX_W-1:0] r_line_cnt;

  logic             w_hs_rise;
  logic             w_frame;
  logic             w_line;
  logic             w_beat;
  logic [1:0]       w_cfg_mode;
  logic [1:0]       w_state_nxt;
  logic [1:0]       w_px_nxt;
  logic [1:0]       w_py_nxt;

  assign w_hs_rise  = bus.i_hsync & ~r_hs_last;
  assign w_frame    = w_hs_rise & bus.i_vsync;
  // An hsync edge only closes a line once the frame has seen its first beat.
  assign w_line     = w_hs_rise & ~bus.i_vsync & ((r_state == ST_ACTIVE) | (r_state == ST_HBLANK));
  assign w_beat     = bus.i_valid & ~w_hs_rise & (r_state != ST_IDLE);
  assign w_cfg_mode = (bus.i_cfg_mode == 2'd3) ? MODE_MONO : bus.i_cfg_mode;

  always_comb begin
    w_state_nxt = r_state;
    if (w_frame) begin
      w_state_nxt = ST_VBLANK;
    end else begin
      case (r_state)
        ST_VBLANK: if (w_beat)    w_state_nxt = ST_ACTIVE;
        ST_ACTIVE: if (w_hs_rise) w_state_nxt = ST_HBLANK;
        ST_HBLANK: if (w_beat)    w_state_nxt = ST_ACTIVE;
        default:                  w_state_nxt = r_state;
      endcase
    end
  end

  // Phases for the next beat; frame start looks at the mode about to be applied.
  always_comb begin
    w_px_nxt = r_phase_x;
    w_py_nxt = r_phase_y;
    if (w_frame) begin
      w_px_nxt = 2'd0;
      w_py_nxt = (r_pending == MODE_TRI) ? 2'd1 : 2'd0;
    end else if (w_line) begin
      case (r_mode)
        MODE_TRI: begin
          w_px_nxt = r_phase_y;
          w_py_nxt = (r_phase_y == 2'd2) ? 2'd0 : r_phase_y + 2'd1;
        end
        MODE_RGBW: begin
          w_px_nxt = 2'd0;
          w_py_nxt = {1'b0, ~r_phase_y[0]};
        end
        default: begin
          w_px_nxt = 2'd0;
          w_py_nxt = 2'd0;
        end
      endcase
    end else if (w_beat) begin
      if (r_mode == MODE_TRI) begin
        w_px_nxt = (r_phase_x == 2'd2) ? 2'd0 : r_phase_x + 2'd1;
      end else begin
        w_px_nxt = 2'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_hs_last     <= 1'b0;
      r_frame_start <= 1'b0;
      r_phase_x     <= 2'd0;
      r_phase_y     <= 2'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_hs_last     <= bus.i_hsync;
      r_frame_start <= w_frame;
      r_phase_x     <= w_px_nxt;
      r_phase_y     <= w_py_nxt;
    end
  end

  // A write on the frame-start cycle lands in pending after the old value is applied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode    <= DEF_MODE;
      r_pending <= DEF_MODE;
    end else begin
      if (w_frame) begin
        r_mode <= r_pending;
      end
      if (bus.i_cfg_wr) begin
        r_pending <= w_cfg_mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_cnt  <= '0;
      r_line_cnt <= '0;
    end else if (w_frame) begin
      r_pix_cnt  <= '0;
      r_line_cnt <= '0;
    end else if (w_line) begin
      r_pix_cnt <= '0;
      if (r_line_cnt != CNT_MAX) begin
        r_line_cnt <= r_line_cnt + CNT_ONE;
      end
    end else if (w_beat && (r_pix_cnt != CNT_MAX)) begin
      r_pix_cnt <= r_pix_cnt + CNT_ONE;
    end
  end

`ifdef VIN_SEQ_LINECHK_EN
  logic [PIX_W-1:0] r_ref_len;
  logic             r_ref_vld;
  logic             r_line_err;

  // The first completed line sets the reference; a vsync abort is never compared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref_len  <= '0;
      r_ref_vld  <= 1'b0;
      r_line_err <= 1'b0;
    end else if (w_frame) begin
      r_ref_vld  <= 1'b0;
      r_line_err <= 1'b0;
    end else if (w_line) begin
      if (!r_ref_vld) begin
        r_ref_len <= r_pix_cnt;
        r_ref_vld <= 1'b1;
      end else if (r_pix_cnt != r_ref_len) begin
        r_line_err <= 1'b1;
      end
    end
  end

  assign bus.o_line_err = r_line_err;
`else
  assign bus.o_line_err = 1'b0;
`endif

  assign bus.o_phase_x     = r_phase_x;
  assign bus.o_phase_y     = r_phase_y;
  assign bus.o_mode        = r_mode;
  assign bus.o_frame_start = r_frame_start;
  assign bus.o_pix_cnt     = r_pix_cnt;
  assign bus.o_line_cnt    = r_line_cnt;

endmodule

// File: tb/tb_vin_cfa_sequencer.sv
// Scoreboard bench for vin_cfa_sequencer: stimulus queues expected beat/frame responses,
// a negedge monitor pops and compares them when a beat or frame_start pulse is presented.
module tb_vin_cfa_sequencer;

  localparam int unsigned PIX_W = 12;
`ifdef VIN_SEQ_LINECHK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  typedef struct {
    logic [1:0] px;
    logic [1:0] py;
    logic [1:0] md;
    int         pix;
    int         line;
    logic       err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  exp_t beatQ[$];
  exp_t frameQ[$];

  vin_cfa_sequencer_if #(.PIX_W(PIX_W)) bus ();

  vin_cfa_sequencer #(.PIX_W(PIX_W), .DEF_MODE(2'd0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  task automatic applyStimulus(input logic vs, input logic hs, input logic v,
                               input logic wr, input logic [1:0] m);
    bus.i_vsync    = vs;
    bus.i_hsync    = hs;
    bus.i_valid    = v;
    bus.i_cfg_wr   = wr;
    bus.i_cfg_mode = m;
    @(posedge clk);
    #1;
  endtask

  task automatic expBeat(input logic [1:0] px, input logic [1:0] py, input logic [1:0] md,
                         input int pix, input int line, input logic err);
    exp_t e;
    e.px = px; e.py = py; e.md = md; e.pix = pix; e.line = line; e.err = err;
    beatQ.push_back(e);
  endtask

  task automatic beat(input logic [1:0] px, input logic [1:0] py, input logic [1:0] md,
                      input int pix, input int line, input logic err);
    expBeat(px, py, md, pix, line, err);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
  endtask

  task automatic lineEdge();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic cfgWrite(input logic [1:0] m);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, m);
  endtask

  task automatic frameStart(input logic wr, input logic [1:0] m,
                            input logic [1:0] expMode, input logic [1:0] expPy);
    exp_t e;
    e.px = 2'd0; e.py = expPy; e.md = expMode; e.pix = 0; e.line = 0; e.err = 1'b0;
    frameQ.push_back(e);
    applyStimulus(1'b1, 1'b1, 1'b0, wr, m);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic checkReset();
    checkOutput("rst_phase_x", 32'(bus.o_phase_x), 0);
    checkOutput("rst_phase_y", 32'(bus.o_phase_y), 0);
    checkOutput("rst_mode", 32'(bus.o_mode), 0);
    checkOutput("rst_frame_start", 32'(bus.o_frame_start), 0);
    checkOutput("rst_pix_cnt", 32'(bus.o_pix_cnt), 0);
    checkOutput("rst_line_cnt", 32'(bus.o_line_cnt), 0);
    checkOutput("rst_line_err", 32'(bus.o_line_err), 0);
  endtask

  // Monitor: a beat presented on i_valid or a frame_start pulse consumes one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.i_valid) begin
        if (beatQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL beat_unexpected at %0t: got beat expected none", $time);
        end else begin
          e = beatQ.pop_front();
          checkOutput("beat_phase_x", 32'(bus.o_phase_x), 32'(e.px));
          checkOutput("beat_phase_y", 32'(bus.o_phase_y), 32'(e.py));
          checkOutput("beat_mode", 32'(bus.o_mode), 32'(e.md));
          checkOutput("beat_pix_cnt", 32'(bus.o_pix_cnt), e.pix);
          checkOutput("beat_line_cnt", 32'(bus.o_line_cnt), e.line);
          checkOutput("beat_line_err", 32'(bus.o_line_err), 32'(e.err));
        end
      end
      if (bus.o_frame_start) begin
        if (frameQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL frame_unexpected at %0t: got pulse expected none", $time);
        end else begin
          e = frameQ.pop_front();
          checkOutput("frame_mode", 32'(bus.o_mode), 32'(e.md));
          checkOutput("frame_phase_x", 32'(bus.o_phase_x), 32'(e.px));
          checkOutput("frame_phase_y", 32'(bus.o_phase_y), 32'(e.py));
          checkOutput("frame_pix_cnt", 32'(bus.o_pix_cnt), e.pix);
          checkOutput("frame_line_cnt", 32'(bus.o_line_cnt), e.line);
          checkOutput("frame_line_err", 32'(bus.o_line_err), 32'(e.err));
        end
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    bus.i_vsync    = 1'b0;
    bus.i_hsync    = 1'b0;
    bus.i_valid    = 1'b0;
    bus.i_cfg_wr   = 1'b0;
    bus.i_cfg_mode = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    checkReset();
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

    // TRI frame: IDLE beats ignored, VBLANK hsync ignored, 4 lines of 6 beats
    cfgWrite(2'd1);
    beat(2'd0, 2'd0, 2'd0, 0, 0, 1'b0);
    beat(2'd0, 2'd0, 2'd0, 0, 0, 1'b0);
    frameStart(1'b0, 2'd0, 2'd1, 2'd1);
    expBeat(2'd0, 2'd1, 2'd1, 0, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 6; i++) begin
        beat(2'((l + i) % 3), 2'((1 + l) % 3), 2'd1, i, l, 1'b0);
      end
      if (l < 3) lineEdge();
    end
    cfgWrite(2'd2);
    beat(2'd0, 2'd1, 2'd1, 6, 3, 1'b0);

    // RGBW frame: 3 lines of 4 beats
    frameStart(1'b0, 2'd0, 2'd2, 2'd0);
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 4; i++) begin
        beat(2'd0, 2'(l % 2), 2'd2, i, l, 1'b0);
      end
      if (l < 2) lineEdge();
    end
    cfgWrite(2'd0);
    beat(2'd0, 2'd0, 2'd2, 4, 2, 1'b0);

    // MONO frame with a mid-frame write, then a write on the frame-start cycle
    frameStart(1'b0, 2'd0, 2'd0, 2'd0);
    beat(2'd0, 2'd0, 2'd0, 0, 0, 1'b0);
    beat(2'd0, 2'd0, 2'd0, 1, 0, 1'b0);
    cfgWrite(2'd2);
    beat(2'd0, 2'd0, 2'd0, 2, 0, 1'b0);
    lineEdge();
    beat(2'd0, 2'd0, 2'd0, 0, 1, 1'b0);
    frameStart(1'b1, 2'd1, 2'd2, 2'd0);
    beat(2'd0, 2'd0, 2'd2, 0, 0, 1'b0);
    frameStart(1'b0, 2'd0, 2'd1, 2'd1);

    // hsync edge coincident with a beat, then vsync abort mid-line
    beat(2'd0, 2'd1, 2'd1, 0, 0, 1'b0);
    beat(2'd1, 2'd1, 2'd1, 1, 0, 1'b0);
    beat(2'd2, 2'd1, 2'd1, 2, 0, 1'b0);
    expBeat(2'd0, 2'd1, 2'd1, 3, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    beat(2'd1, 2'd2, 2'd1, 0, 1, 1'b0);
    frameStart(1'b0, 2'd0, 2'd1, 2'd1);
    beat(2'd0, 2'd1, 2'd1, 0, 0, 1'b0);

    // Reserved mode reads as MONO; lines of 8, 8, 7 beats
    cfgWrite(2'd3);
    frameStart(1'b0, 2'd0, 2'd0, 2'd0);
    for (int i = 0; i < 8; i++) beat(2'd0, 2'd0, 2'd0, i, 0, 1'b0);
    lineEdge();
    for (int i = 0; i < 8; i++) beat(2'd0, 2'd0, 2'd0, i, 1, 1'b0);
    lineEdge();
    for (int i = 0; i < 7; i++) beat(2'd0, 2'd0, 2'd0, i, 2, 1'b0);
    lineEdge();
    beat(2'd0, 2'd0, 2'd0, 0, 3, CHK);
    frameStart(1'b0, 2'd0, 2'd0, 2'd0);
    beat(2'd0, 2'd0, 2'd0, 0, 0, 1'b0);

    // Asynchronous reset mid-line, then recovery at the next frame start
    cfgWrite(2'd2);
    frameStart(1'b0, 2'd0, 2'd2, 2'd0);
    beat(2'd0, 2'd0, 2'd2, 0, 0, 1'b0);
    beat(2'd0, 2'd0, 2'd2, 1, 0, 1'b0);
    rst_n = 1'b0;
    #2;
    checkReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    beat(2'd0, 2'd0, 2'd0, 0, 0, 1'b0);
    frameStart(1'b0, 2'd0, 2'd0, 2'd0);
    beat(2'd0, 2'd0, 2'd0, 0, 0, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

    checkOutput("beat_queue_drained", 32'(beatQ.size()), 0);
    checkOutput("frame_queue_drained", 32'(frameQ.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
